circular_queue_ctrl: RTL and testbench
======================================

Name: circular_queue_ctrl

Overview:
Parametrised enqueue/dequeue pointer controller for circular queues of any depth, power-of-2 or not. It supports multi-entry enqueue and dequeue per cycle, enqueue-pointer rollback and flush. It exposes vectors of consecutive pointers per port plus occupancy status. It is used as the pointer/occupancy core for issue queues, load/store queues and ROB-like buffers; the storage array lives outside the block.

Parameters:
ENTRIES, 12, queue depth; must be >= 2 and >= max(ENQ_WIDTH, DEQ_WIDTH).
ENQ_WIDTH, 4, maximum entries enqueued per cycle; also the enqueue pointer vector length.
DEQ_WIDTH, 4, maximum entries dequeued per cycle; also the dequeue pointer vector length.
PTR_WIDTH, $clog2(ENTRIES), derived, do not override; width of the pointer value field.
CNT_WIDTH, $clog2(ENTRIES+1), derived, do not override; width of the count outputs.
ENQ_NUM_W, $clog2(ENQ_WIDTH+1), derived, do not override; width of enq_num_i.
DEQ_NUM_W, $clog2(DEQ_WIDTH+1), derived, do not override; width of deq_num_i.

Ports:
clk_i  in  1  clock; single clock domain
rst_ni  in  1  asynchronous active-low reset
enq_num_i  in  ENQ_NUM_W  number of entries to enqueue this cycle (0..ENQ_WIDTH)
enq_accept_o  out  1  comb; 1 when enq_num_i <= free_cnt_o and no flush/rollback this cycle
deq_num_i  in  DEQ_NUM_W  number of entries to dequeue this cycle (0..DEQ_WIDTH)
deq_accept_o  out  1  comb; 1 when deq_num_i <= valid_cnt_o and no flush this cycle
rollback_i  in  1  load enqueue pointer from rollback_flag_i/rollback_value_i
rollback_flag_i  in  1  rollback target flag
rollback_value_i  in  PTR_WIDTH  rollback target value
flush_i  in  1  empty the queue
enq_ptr_flag_o  out  ENQ_WIDTH  lane i carries the flag of (enq_ptr + i)
enq_ptr_value_o  out  ENQ_WIDTH*PTR_WIDTH  lane i carries the value of (enq_ptr + i)
deq_ptr_flag_o  out  DEQ_WIDTH  lane i carries the flag of (deq_ptr + i)
deq_ptr_value_o  out  DEQ_WIDTH*PTR_WIDTH  lane i carries the value of (deq_ptr + i)
valid_cnt_o  out  CNT_WIDTH  occupied entries
free_cnt_o  out  CNT_WIDTH  ENTRIES - valid_cnt_o
empty_o  out  1  valid_cnt_o == 0
full_o  out  1  valid_cnt_o == ENTRIES

Behaviour:
- Clock and reset: clk_i is the only clock. rst_ni is asynchronous, active-low.
- State: two registered pointers, enq_ptr and deq_ptr. Each is {flag, value} with value in 0..ENTRIES-1. All outputs are combinational from registered state and inputs.
- Reset values:
  - both pointers {0,0}; valid_cnt_o 0; free_cnt_o ENTRIES; empty_o 1; full_o 0.
  - lane i of each pointer vector shows {0,i}; for i >= ENTRIES the value wraps and the flag toggles.
  - accept outputs follow the combinational rules with zero counts.
- Pointer add (ptr + k, 0 <= k <= ENTRIES):
  - Power-of-2 ENTRIES: {flag,value}+k in PTR_WIDTH+1 bits.
  - Otherwise: s = value + k in PTR_WIDTH+1 bits. If s >= ENTRIES, then value = s - ENTRIES and flag toggles; else value = s.
- Count:
  - flags equal: enq.value - deq.value
  - flags differ: ENTRIES - deq.value + enq.value
- Counts are computed from registered pointers only. There is no same-cycle bypass, so entries freed by a dequeue become free the next cycle.
- Requests are all-or-nothing. A rejected enqueue or dequeue leaves its pointer unchanged, with no partial acceptance.
- Next-state priority, highest first:
  1. flush_i: both pointers go to {0,0}; enq and deq are ignored; both accepts are 0.
  2. rollback_i: enq_ptr takes the rollback target; enqueue is ignored and enq_accept_o is 0; an accepted dequeue still advances deq_ptr.
  3. Normal: enq_ptr += enq_num_i if accepted; deq_ptr += deq_num_i if accepted; the two are independent and both may occur in the same cycle.
- Rollback legality: the target must satisfy distance(deq_ptr, target) <= valid_cnt_o. An illegal target is a simulation assertion error; RTL behaviour for it is don't-care.
- A num input of 0 is always accepted and is a no-op.
- Reset asserted mid-operation returns the block to the reset state immediately, with no pending effects.
- Assertions:
  - enq_num_i <= ENQ_WIDTH and deq_num_i <= DEQ_WIDTH.
  - valid_cnt_o <= ENTRIES.
  - rollback legality as above.

Decomposition:
- Package circ_queue_pkg holds a parameterised virtual class circ_ptr_util #(ENTRIES) with static functions:
  - ptr_add(flag, value, k)
  - ptr_distance(a, b)
  - is_pow2()
- Sub-module circ_ptr_adder (combinational ptr + constant/variable k).
- circ_ptr_adder is instantiated for the two next-state adders and for each output lane.

Test Plan:
- Reset with ENTRIES=12, ENQ/DEQ_WIDTH=4 -> valid 0, free 12, empty 1; enq lanes {0,0},{0,1},{0,2},{0,3}.
- Enqueue 4 on three consecutive cycles -> enq_ptr {1,0}, full 1, free 0. A following enq_num_i=1 gives enq_accept_o 0 and the pointer is unchanged.
- Non-pow2 wrap: enq_ptr {0,10}, deq_ptr {0,8}, enq 3 -> lanes before update {0,10},{0,11},{1,0},{1,1}; next enq_ptr {1,1}; valid 5.
- valid 5, enq 2 and deq 3 in the same cycle -> both accepted, valid 4 next cycle. With valid 2, deq 3 -> deq_accept_o 0 and deq_ptr unchanged.
- Rollback and flush:
  - deq {0,3}, enq {0,9}, rollback to {0,5} with enq 2 and deq 1 -> enq_ptr {0,5}, deq_ptr {0,4}, valid 1.
  - Then flush and rollback together -> both pointers {0,0}, empty 1.
- ENTRIES=16 config, wrap and reset:
  - enq_ptr {0,15}, enq 4 -> {1,3}, deq_ptr unchanged.
  - Assert rst_ni asynchronously mid-cycle -> all pointers 0 before the next clock edge.

Source files
------------

// File: rtl/circ_queue_pkg.sv
// Pointer arithmetic helpers shared by the circular queue controller and its checks.
// Pointers are {flag, value}; the flag toggles on every wrap past ENTRIES-1.
package circ_queue_pkg;

   virtual class circ_ptr_util #(parameter int unsigned ENTRIES = 2);
      localparam int unsigned PtrW = $clog2(ENTRIES);
      typedef logic [PtrW:0] ptr_t;

      static function bit is_pow2();
         return (ENTRIES & (ENTRIES - 1)) == 0;
      endfunction

      static function ptr_t ptr_add(logic flag, logic [PtrW-1:0] value, int unsigned k);
         int unsigned s;
         logic        f;
         if (is_pow2()) begin
            return ptr_t'({flag, value}) + ptr_t'(k);
         end
         s = k + value;
         f = flag;
         if (s >= ENTRIES) begin
            s = s - ENTRIES;
            f = ~f;
         end
         return {f, PtrW'(s)};
      endfunction

      // Entries from a to b walking forward; negative when b is behind a.
      static function int ptr_distance(ptr_t a, ptr_t b);
         if (a[PtrW] == b[PtrW]) begin
            return int'(b[PtrW-1:0]) - int'(a[PtrW-1:0]);
         end
         return int'(ENTRIES) - int'(a[PtrW-1:0]) + int'(b[PtrW-1:0]);
      endfunction
   endclass

endpackage

// File: rtl/circ_ptr_adder.sv
// Combinational {flag, value} + k for a circular queue of ENTRIES slots.
// Non-power-of-2 depths wrap by subtracting ENTRIES and toggling the flag.
module circ_ptr_adder #(
   parameter int unsigned ENTRIES   = 12,
   parameter int unsigned K_WIDTH   = 3,
   parameter int unsigned PTR_WIDTH = $clog2(ENTRIES)
) (
   input  logic                 flag_i,
   input  logic [PTR_WIDTH-1:0] value_i,
   input  logic [K_WIDTH-1:0]   k_i,
   output logic                 flag_o,
   output logic [PTR_WIDTH-1:0] value_o
);

   localparam int unsigned SumW   = PTR_WIDTH + 1;
   localparam bit          IsPow2 = (ENTRIES & (ENTRIES - 1)) == 0;

   if (IsPow2) begin : g_pow2
      assign {flag_o, value_o} = {flag_i, value_i} + SumW'(k_i);
   end else begin : g_wrap
      logic [SumW-1:0] sum;

      always_comb begin
         sum = {1'b0, value_i} + SumW'(k_i);
         if (sum >= SumW'(ENTRIES)) begin
            value_o = PTR_WIDTH'(sum - SumW'(ENTRIES));
            flag_o  = ~flag_i;
         end else begin
            value_o = sum[PTR_WIDTH-1:0];
            flag_o  = flag_i;
         end
      end
   end

endmodule

// File: rtl/circular_queue_ctrl.sv
// Enqueue/dequeue pointer and occupancy core for a circular queue of any depth.
// Supports multi-entry enq/deq per cycle, enqueue rollback and flush.
module circular_queue_ctrl
   import circ_queue_pkg::*;
#(
   parameter int unsigned ENTRIES   = 12,
   parameter int unsigned ENQ_WIDTH = 4,
   parameter int unsigned DEQ_WIDTH = 4,
   parameter int unsigned PTR_WIDTH = $clog2(ENTRIES),
   parameter int unsigned CNT_WIDTH = $clog2(ENTRIES + 1),
   parameter int unsigned ENQ_NUM_W = $clog2(ENQ_WIDTH + 1),
   parameter int unsigned DEQ_NUM_W = $clog2(DEQ_WIDTH + 1)
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [ENQ_NUM_W-1:0]           enq_num_i,
   output logic                           enq_accept_o,
   input  logic [DEQ_NUM_W-1:0]           deq_num_i,
   output logic                           deq_accept_o,
   input  logic                           rollback_i,
   input  logic                           rollback_flag_i,
   input  logic [PTR_WIDTH-1:0]           rollback_value_i,
   input  logic                           flush_i,
   output logic [ENQ_WIDTH-1:0]           enq_ptr_flag_o,
   output logic [ENQ_WIDTH*PTR_WIDTH-1:0] enq_ptr_value_o,
   output logic [DEQ_WIDTH-1:0]           deq_ptr_flag_o,
   output logic [DEQ_WIDTH*PTR_WIDTH-1:0] deq_ptr_value_o,
   output logic [CNT_WIDTH-1:0]           valid_cnt_o,
   output logic [CNT_WIDTH-1:0]           free_cnt_o,
   output logic                           empty_o,
   output logic                           full_o
);

   logic                 enq_flag_q, enq_flag_d, deq_flag_q, deq_flag_d;
   logic [PTR_WIDTH-1:0] enq_value_q, enq_value_d, deq_value_q, deq_value_d;
   logic                 enq_sum_flag, deq_sum_flag;
   logic [PTR_WIDTH-1:0] enq_sum_value, deq_sum_value;
   logic [CNT_WIDTH-1:0] valid_cnt;

   // Occupancy comes from registered pointers only; no same-cycle bypass.
   always_comb begin
      if (enq_flag_q == deq_flag_q) begin
         valid_cnt = CNT_WIDTH'(enq_value_q) - CNT_WIDTH'(deq_value_q);
      end else begin
         valid_cnt = CNT_WIDTH'(ENTRIES) - CNT_WIDTH'(deq_value_q) + CNT_WIDTH'(enq_value_q);
      end
   end

   assign valid_cnt_o  = valid_cnt;
   assign free_cnt_o   = CNT_WIDTH'(ENTRIES) - valid_cnt;
   assign empty_o      = (valid_cnt == '0);
   assign full_o       = (valid_cnt == CNT_WIDTH'(ENTRIES));
   assign enq_accept_o = !flush_i && !rollback_i && (CNT_WIDTH'(enq_num_i) <= free_cnt_o);
   assign deq_accept_o = !flush_i && (CNT_WIDTH'(deq_num_i) <= valid_cnt);

   circ_ptr_adder #(
      .ENTRIES   (ENTRIES),
      .K_WIDTH   (ENQ_NUM_W),
      .PTR_WIDTH (PTR_WIDTH)
   ) u_enq_next (
      .flag_i  (enq_flag_q),
      .value_i (enq_value_q),
      .k_i     (enq_num_i),
      .flag_o  (enq_sum_flag),
      .value_o (enq_sum_value)
   );

   circ_ptr_adder #(
      .ENTRIES   (ENTRIES),
      .K_WIDTH   (DEQ_NUM_W),
      .PTR_WIDTH (PTR_WIDTH)
   ) u_deq_next (
      .flag_i  (deq_flag_q),
      .value_i (deq_value_q),
      .k_i     (deq_num_i),
      .flag_o  (deq_sum_flag),
      .value_o (deq_sum_value)
   );

   for (genvar i = 0; i < ENQ_WIDTH; i++) begin : g_enq_lane
      circ_ptr_adder #(
         .ENTRIES   (ENTRIES),
         .K_WIDTH   (ENQ_NUM_W),
         .PTR_WIDTH (PTR_WIDTH)
      ) u_lane (
         .flag_i  (enq_flag_q),
         .value_i (enq_value_q),
         .k_i     (ENQ_NUM_W'(i)),
         .flag_o  (enq_ptr_flag_o[i]),
         .value_o (enq_ptr_value_o[i*PTR_WIDTH +: PTR_WIDTH])
      );
   end

   for (genvar i = 0; i < DEQ_WIDTH; i++) begin : g_deq_lane
      circ_ptr_adder #(
         .ENTRIES   (ENTRIES),
         .K_WIDTH   (DEQ_NUM_W),
         .PTR_WIDTH (PTR_WIDTH)
      ) u_lane (
         .flag_i  (deq_flag_q),
         .value_i (deq_value_q),
         .k_i     (DEQ_NUM_W'(i)),
         .flag_o  (deq_ptr_flag_o[i]),
         .value_o (deq_ptr_value_o[i*PTR_WIDTH +: PTR_WIDTH])
      );
   end

   // Flush beats rollback beats normal enqueue; dequeue survives rollback.
   always_comb begin
      enq_flag_d  = enq_flag_q;
      enq_value_d = enq_value_q;
      deq_flag_d  = deq_flag_q;
      deq_value_d = deq_value_q;
      if (flush_i) begin
         enq_flag_d  = 1'b0;
         enq_value_d = '0;
         deq_flag_d  = 1'b0;
         deq_value_d = '0;
      end else begin
         if (rollback_i) begin
            enq_flag_d  = rollback_flag_i;
            enq_value_d = rollback_value_i;
         end else if (enq_accept_o) begin
            enq_flag_d  = enq_sum_flag;
            enq_value_d = enq_sum_value;
         end
         if (deq_accept_o) begin
            deq_flag_d  = deq_sum_flag;
            deq_value_d = deq_sum_value;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         enq_flag_q  <= 1'b0;
         enq_value_q <= '0;
         deq_flag_q  <= 1'b0;
         deq_value_q <= '0;
      end else begin
         enq_flag_q  <= enq_flag_d;
         enq_value_q <= enq_value_d;
         deq_flag_q  <= deq_flag_d;
         deq_value_q <= deq_value_d;

         assert (enq_num_i <= ENQ_NUM_W'(ENQ_WIDTH))
            else $error("enq_num_i exceeds ENQ_WIDTH");
         assert (deq_num_i <= DEQ_NUM_W'(DEQ_WIDTH))
            else $error("deq_num_i exceeds DEQ_WIDTH");
         assert (valid_cnt <= CNT_WIDTH'(ENTRIES))
            else $error("valid count exceeds ENTRIES");
         if (rollback_i && !flush_i) begin
            assert (circ_ptr_util#(ENTRIES)::ptr_distance({deq_flag_q, deq_value_q},
                       {rollback_flag_i, rollback_value_i}) >= 0 &&
                    circ_ptr_util#(ENTRIES)::ptr_distance({deq_flag_q, deq_value_q},
                       {rollback_flag_i, rollback_value_i}) <= int'(valid_cnt))
               else $error("rollback target outside occupied range");
         end
      end
   end

endmodule

// File: tb/tb_circular_queue_ctrl.sv
// Directed bench: a 12-entry instance (a_*) and a 16-entry instance (b_*).
module tb_circular_queue_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   logic [2:0]  a_enq_num, a_deq_num;
   logic        a_rb, a_rb_flag, a_flush, a_enq_acc, a_deq_acc, a_empty, a_full;
   logic [3:0]  a_rb_val, a_enq_flag, a_deq_flag, a_valid, a_free;
   logic [15:0] a_enq_val, a_deq_val;

   logic [2:0]  b_enq_num, b_deq_num;
   logic        b_rb, b_rb_flag, b_flush, b_enq_acc, b_deq_acc, b_empty, b_full;
   logic [3:0]  b_rb_val, b_enq_flag, b_deq_flag;
   logic [4:0]  b_valid, b_free;
   logic [15:0] b_enq_val, b_deq_val;

   circular_queue_ctrl #(.ENTRIES(12), .ENQ_WIDTH(4), .DEQ_WIDTH(4)) u_dut_a (
      .clk_i(clk), .rst_ni(rst_n),
      .enq_num_i(a_enq_num), .enq_accept_o(a_enq_acc),
      .deq_num_i(a_deq_num), .deq_accept_o(a_deq_acc),
      .rollback_i(a_rb), .rollback_flag_i(a_rb_flag), .rollback_value_i(a_rb_val),
      .flush_i(a_flush),
      .enq_ptr_flag_o(a_enq_flag), .enq_ptr_value_o(a_enq_val),
      .deq_ptr_flag_o(a_deq_flag), .deq_ptr_value_o(a_deq_val),
      .valid_cnt_o(a_valid), .free_cnt_o(a_free), .empty_o(a_empty), .full_o(a_full)
   );

   circular_queue_ctrl #(.ENTRIES(16), .ENQ_WIDTH(4), .DEQ_WIDTH(4)) u_dut_b (
      .clk_i(clk), .rst_ni(rst_n),
      .enq_num_i(b_enq_num), .enq_accept_o(b_enq_acc),
      .deq_num_i(b_deq_num), .deq_accept_o(b_deq_acc),
      .rollback_i(b_rb), .rollback_flag_i(b_rb_flag), .rollback_value_i(b_rb_val),
      .flush_i(b_flush),
      .enq_ptr_flag_o(b_enq_flag), .enq_ptr_value_o(b_enq_val),
      .deq_ptr_flag_o(b_deq_flag), .deq_ptr_value_o(b_deq_val),
      .valid_cnt_o(b_valid), .free_cnt_o(b_free), .empty_o(b_empty), .full_o(b_full)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic [2:0] enq, input logic [2:0] deq);
      a_enq_num = enq; a_deq_num = deq; a_rb = 1'b0; a_flush = 1'b0;
   endtask

   task automatic drive_b(input logic [2:0] enq, input logic [2:0] deq);
      b_enq_num = enq; b_deq_num = deq; b_rb = 1'b0; b_flush = 1'b0;
   endtask

   task automatic flush_a();
      drive_a(3'd0, 3'd0); a_flush = 1'b1; tick(); a_flush = 1'b0;
   endtask

   task automatic test_reset();
      drive_a(3'd0, 3'd1);
      #1;
      total++; if (a_valid !== 4'd0) begin bad++; $display("FAIL reset_valid got=%0d want=0", a_valid); end
      total++; if (a_free !== 4'd12) begin bad++; $display("FAIL reset_free got=%0d want=12", a_free); end
      total++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin
         bad++; $display("FAIL reset_empty_full got=%b%b want=10", a_empty, a_full); end
      total++; if (a_enq_val !== 16'h3210 || a_enq_flag !== 4'h0) begin
         bad++; $display("FAIL reset_enq_lanes got=%h/%h want=3210/0", a_enq_val, a_enq_flag); end
      total++; if (a_enq_acc !== 1'b1 || a_deq_acc !== 1'b0) begin
         bad++; $display("FAIL reset_accepts got=%b%b want=10", a_enq_acc, a_deq_acc); end
      total++; if (b_free !== 5'd16) begin bad++; $display("FAIL reset_free_b got=%0d want=16", b_free); end
      drive_a(3'd0, 3'd0);
      tick();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 3; i++) begin
         drive_a(3'd4, 3'd0);
         #1;
         total++; if (a_enq_acc !== 1'b1) begin
            bad++; $display("FAIL fill_accept%0d got=%b want=1", i, a_enq_acc); end
         tick();
      end
      drive_a(3'd0, 3'd0);
      #1;
      total++; if (a_full !== 1'b1 || a_free !== 4'd0 || a_valid !== 4'd12) begin
         bad++; $display("FAIL fill_full got=%b/%0d/%0d want=1/0/12", a_full, a_free, a_valid); end
      total++; if (a_enq_flag !== 4'hF || a_enq_val !== 16'h3210) begin
         bad++; $display("FAIL fill_ptr got=%h/%h want=F/3210", a_enq_flag, a_enq_val); end
      drive_a(3'd1, 3'd0);
      #1;
      total++; if (a_enq_acc !== 1'b0) begin bad++; $display("FAIL full_reject got=%b want=0", a_enq_acc); end
      tick();
      drive_a(3'd0, 3'd0);
      total++; if (a_enq_flag !== 4'hF || a_enq_val !== 16'h3210 || a_valid !== 4'd12) begin
         bad++; $display("FAIL full_hold got=%h/%h/%0d want=F/3210/12", a_enq_flag, a_enq_val, a_valid);
      end
   endtask

   task automatic test_wrap();
      flush_a();
      total++; if (a_empty !== 1'b1) begin bad++; $display("FAIL flush_empty got=%b want=1", a_empty); end
      drive_a(3'd4, 3'd0); tick();
      drive_a(3'd4, 3'd4); tick();
      drive_a(3'd2, 3'd4); tick();
      drive_a(3'd3, 3'd0);
      #1;
      total++; if (a_valid !== 4'd2) begin bad++; $display("FAIL wrap_setup got=%0d want=2", a_valid); end
      total++; if (a_enq_val !== 16'h10BA || a_enq_flag !== 4'b1100) begin
         bad++; $display("FAIL wrap_lanes got=%h/%b want=10ba/1100", a_enq_val, a_enq_flag); end
      total++; if (a_enq_acc !== 1'b1) begin bad++; $display("FAIL wrap_accept got=%b want=1", a_enq_acc); end
      tick();
      drive_a(3'd0, 3'd0);
      total++; if (a_valid !== 4'd5) begin bad++; $display("FAIL wrap_valid got=%0d want=5", a_valid); end
      total++; if (a_enq_val !== 16'h4321 || a_enq_flag !== 4'hF) begin
         bad++; $display("FAIL wrap_next got=%h/%h want=4321/F", a_enq_val, a_enq_flag); end
   endtask

   task automatic test_back_to_back();
      drive_a(3'd2, 3'd3);
      #1;
      total++; if (a_enq_acc !== 1'b1 || a_deq_acc !== 1'b1) begin
         bad++; $display("FAIL b2b_accepts got=%b%b want=11", a_enq_acc, a_deq_acc); end
      tick();
      drive_a(3'd0, 3'd0);
      total++; if (a_valid !== 4'd4) begin bad++; $display("FAIL b2b_valid got=%0d want=4", a_valid); end
      total++; if (a_deq_val !== 16'h210B || a_deq_flag !== 4'b1110) begin
         bad++; $display("FAIL b2b_deq_lanes got=%h/%b want=210b/1110", a_deq_val, a_deq_flag); end
      drive_a(3'd0, 3'd2); tick();
      drive_a(3'd0, 3'd3);
      #1;
      total++; if (a_valid !== 4'd2 || a_deq_acc !== 1'b0) begin
         bad++; $display("FAIL deq_reject got=%0d/%b want=2/0", a_valid, a_deq_acc); end
      tick();
      drive_a(3'd0, 3'd0);
      total++; if (a_deq_val !== 16'h4321 || a_deq_flag !== 4'hF || a_valid !== 4'd2) begin
         bad++; $display("FAIL deq_hold got=%h/%h/%0d want=4321/F/2", a_deq_val, a_deq_flag, a_valid);
      end
   endtask

   task automatic test_rollback_flush();
      flush_a();
      drive_a(3'd4, 3'd0); tick();
      drive_a(3'd4, 3'd3); tick();
      drive_a(3'd1, 3'd0); tick();
      drive_a(3'd2, 3'd1);
      a_rb = 1'b1; a_rb_flag = 1'b0; a_rb_val = 4'd5;
      #1;
      total++; if (a_enq_acc !== 1'b0 || a_deq_acc !== 1'b1) begin
         bad++; $display("FAIL rb_accepts got=%b%b want=01", a_enq_acc, a_deq_acc); end
      tick();
      drive_a(3'd0, 3'd0);
      total++; if (a_enq_val !== 16'h8765 || a_deq_val !== 16'h7654 || a_valid !== 4'd1) begin
         bad++; $display("FAIL rb_ptrs got=%h/%h/%0d want=8765/7654/1", a_enq_val, a_deq_val, a_valid);
      end
      drive_a(3'd1, 3'd1);
      a_flush = 1'b1; a_rb = 1'b1; a_rb_flag = 1'b0; a_rb_val = 4'd6;
      #1;
      total++; if (a_enq_acc !== 1'b0 || a_deq_acc !== 1'b0) begin
         bad++; $display("FAIL flush_accepts got=%b%b want=00", a_enq_acc, a_deq_acc); end
      tick();
      drive_a(3'd0, 3'd0);
      total++; if (a_enq_val !== 16'h3210 || a_deq_val !== 16'h3210 || a_empty !== 1'b1 ||
                   a_enq_flag !== 4'h0) begin
         bad++; $display("FAIL flush_ptrs got=%h/%h/%b want=3210/3210/1", a_enq_val, a_deq_val, a_empty);
      end
   endtask

   task automatic test_pow2();
      drive_b(3'd4, 3'd0); tick();
      drive_b(3'd4, 3'd4); tick();
      drive_b(3'd4, 3'd0); tick();
      drive_b(3'd3, 3'd0); tick();
      drive_b(3'd4, 3'd0);
      #1;
      total++; if (b_enq_val !== 16'h210F || b_enq_flag !== 4'b1110 || b_valid !== 5'd11) begin
         bad++; $display("FAIL p2_before got=%h/%b/%0d want=210f/1110/11", b_enq_val, b_enq_flag, b_valid);
      end
      tick();
      drive_b(3'd0, 3'd0);
      total++; if (b_enq_val !== 16'h6543 || b_enq_flag !== 4'hF) begin
         bad++; $display("FAIL p2_wrap got=%h/%h want=6543/F", b_enq_val, b_enq_flag); end
      total++; if (b_deq_val !== 16'h7654 || b_deq_flag !== 4'h0 || b_valid !== 5'd15) begin
         bad++; $display("FAIL p2_deq got=%h/%h/%0d want=7654/0/15", b_deq_val, b_deq_flag, b_valid);
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++; if (b_valid !== 5'd0 || b_empty !== 1'b1) begin
         bad++; $display("FAIL areset_count got=%0d/%b want=0/1", b_valid, b_empty); end
      total++; if (b_enq_val !== 16'h3210 || b_enq_flag !== 4'h0 || b_deq_val !== 16'h3210) begin
         bad++; $display("FAIL areset_ptrs got=%h/%h/%h want=3210/0/3210", b_enq_val, b_enq_flag, b_deq_val);
      end
      #1 rst_n = 1'b1;
      tick();
      total++; if (b_empty !== 1'b1 || a_free !== 4'd12) begin
         bad++; $display("FAIL areset_after got=%b/%0d want=1/12", b_empty, a_free); end
   endtask

   initial begin
      drive_a(3'd0, 3'd0); a_rb_flag = 1'b0; a_rb_val = 4'd0;
      drive_b(3'd0, 3'd0); b_rb_flag = 1'b0; b_rb_val = 4'd0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      tick();
      test_reset();
      test_fill();
      test_wrap();
      test_back_to_back();
      test_rollback_flush();
      test_pow2();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
